speck_decrypt_core: RTL and testbench

Iterative Speck128/128 decryption engine: the inverse of the Speck datapath/control-path pair, turning a 128-bit ciphertext block back into plaintext under a 128-bit key. It expands the key schedule forward into an internal round-key store, then runs the inverse round function once per cycle with the round keys in reverse order. It sits on the processor's decrypt side, fed by the same 64-bit word buses the encrypt/hash datapath uses.

---
 rtl/speck_pkg.sv | 20 ++
 rtl/speck_round_key_ram.sv | 36 +++
 rtl/speck_decrypt_core.sv | 193 +++++++++++++++++++
 tb/tb_speck_decrypt_core.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/speck_pkg.sv
// Shared definitions for the Speck128/128 decrypt slice.
//   SPECK_W / SPECK_ROUNDS / SPECK_ALPHA / SPECK_BETA : cipher geometry
//   SPECK_IDX_W : width of a round index (clog2 of the round count)
//   speck_state_t + ST_* : control FSM encoding used by speck_decrypt_core
package speck_pkg;

  localparam int SPECK_W      = 64;
  localparam int SPECK_ROUNDS = 32;
  localparam int SPECK_ALPHA  = 8;
  localparam int SPECK_BETA   = 3;
  localparam int SPECK_IDX_W  = $clog2(SPECK_ROUNDS);

  typedef logic [1:0] speck_state_t;

  localparam speck_state_t ST_IDLE   = 2'd0;
  localparam speck_state_t ST_KEYEXP = 2'd1;
  localparam speck_state_t ST_DEC    = 2'd2;
  localparam speck_state_t ST_DONE   = 2'd3;

endpackage

// File: rtl/speck_round_key_ram.sv
// Round-key store: ROUNDS x W words, one synchronous write port (filled
// while the key schedule runs forward) and one asynchronous read port
// (consumed in reverse order by the inverse rounds).
//   clk   : write clock
//   we    : write enable
//   waddr : write index
//   wdata : round key to store
//   raddr : read index
//   rdata : round key at raddr, combinational
// No reset: contents are only read after being written by the same run.
module speck_round_key_ram
  import speck_pkg::*;
#(
  parameter int W      = SPECK_W,
  parameter int ROUNDS = SPECK_ROUNDS,
  parameter int IDX_W  = $clog2(ROUNDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [W-1:0]     rdata
);

  logic [W-1:0] mem [ROUNDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/speck_decrypt_core.sv
// Iterative Speck128/128 decryption engine. On an accepted start the key
// schedule is expanded forward into a round-key store (one step per cycle),
// then one inverse round per cycle is applied with the keys in reverse order.
//   clk, reset     : clock, synchronous active-high reset
//   start          : request, sampled only while idle
//   key_l, key_k   : key words l[0] (upper) and k[0] (lower)
//   ct_x, ct_y     : ciphertext words
//   busy           : operation in flight
//   done           : one-cycle pulse, plaintext valid
//   pt_x, pt_y     : plaintext, held until the next completion
// Optional feature macro: SPECK_KEY_CACHE_EN. When defined, the last key pair
// that completed is remembered and a repeated key skips the key schedule.
module speck_decrypt_core
  import speck_pkg::*;
#(
  parameter int W      = SPECK_W,
  parameter int ROUNDS = SPECK_ROUNDS,
  parameter int ALPHA  = SPECK_ALPHA,
  parameter int BETA   = SPECK_BETA
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] key_l,
  input  logic [W-1:0] key_k,
  input  logic [W-1:0] ct_x,
  input  logic [W-1:0] ct_y,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] pt_x,
  output logic [W-1:0] pt_y
);

  localparam int IDX_W = $clog2(ROUNDS);

  function automatic logic [W-1:0] rol(input logic [W-1:0] v, input int n);
    return (v << n) | (v >> (W - n));
  endfunction

  function automatic logic [W-1:0] ror(input logic [W-1:0] v, input int n);
    return (v >> n) | (v << (W - n));
  endfunction

  speck_state_t     state;
  logic [IDX_W-1:0] cnt;     // i during KEYEXP, r during DEC
  logic [W-1:0]     l_q;
  logic [W-1:0]     k_q;
  logic [W-1:0]     x_q;
  logic [W-1:0]     y_q;

  logic [W-1:0]     l_next;
  logic [W-1:0]     k_next;
  logic [W-1:0]     x_next;
  logic [W-1:0]     y_next;
  logic [W-1:0]     rk;

  logic             accept;
  logic             cache_hit;

  logic             ram_we;
  logic [IDX_W-1:0] ram_waddr;
  logic [W-1:0]     ram_wdata;

  assign accept = (state == ST_IDLE) && start;

`ifdef SPECK_KEY_CACHE_EN
  logic             cache_valid;
  logic [2*W-1:0]   cache_key;

  assign cache_hit = cache_valid && ({key_l, key_k} == cache_key);
`else
  assign cache_hit = 1'b0;
`endif

  // Forward key-schedule step; the round counter is zero-extended to W.
  assign l_next = (k_q + ror(l_q, ALPHA)) ^ {{(W-IDX_W){1'b0}}, cnt};
  assign k_next = rol(k_q, BETA) ^ l_next;

  // Inverse round: undo the y update first, then the x update.
  assign y_next = ror(y_q ^ x_q, BETA);
  assign x_next = rol((x_q ^ rk) - y_next, ALPHA);

  // Entry 0 is k[0] itself; each KEYEXP step produces the next entry.
  assign ram_we    = accept || (state == ST_KEYEXP);
  assign ram_waddr = (state == ST_IDLE) ? '0 : cnt + 1'b1;
  assign ram_wdata = (state == ST_IDLE) ? key_k : k_next;

  speck_round_key_ram #(
    .W      (W),
    .ROUNDS (ROUNDS),
    .IDX_W  (IDX_W)
  ) u_rk_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (cnt),
    .rdata (rk)
  );

  // Control path and architectural outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pt_x  <= '0;
      pt_y  <= '0;
`ifdef SPECK_KEY_CACHE_EN
      cache_valid <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (cache_hit) begin
              state <= ST_DEC;
              cnt   <= IDX_W'(ROUNDS - 1);
            end else begin
              state <= ST_KEYEXP;
              cnt   <= '0;
`ifdef SPECK_KEY_CACHE_EN
              // Stored pair is being replaced; not trustworthy until done.
              cache_valid <= 1'b0;
`endif
            end
          end
        end
        ST_KEYEXP: begin
          if (cnt == IDX_W'(ROUNDS - 2)) begin
            state <= ST_DEC;
            cnt   <= IDX_W'(ROUNDS - 1);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DEC: begin
          if (cnt == '0) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pt_x  <= x_next;
            pt_y  <= y_next;
`ifdef SPECK_KEY_CACHE_EN
            cache_valid <= 1'b1;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Datapath working registers (no reset; always loaded before use).
  always_ff @(posedge clk) begin
    case (state)
      ST_IDLE: begin
        if (start) begin
          l_q <= key_l;
          k_q <= key_k;
          x_q <= ct_x;
          y_q <= ct_y;
        end
      end
      ST_KEYEXP: begin
        l_q <= l_next;
        k_q <= k_next;
      end
      ST_DEC: begin
        x_q <= x_next;
        y_q <= y_next;
      end
      default: begin
      end
    endcase
  end

`ifdef SPECK_KEY_CACHE_EN
  always_ff @(posedge clk) begin
    if (accept && !cache_hit) begin
      cache_key <= {key_l, key_k};
    end
  end
`endif

endmodule

// File: tb/tb_speck_decrypt_core.sv
// Directed bench for speck_decrypt_core: reset values, the published
// Speck128/128 vector, zero and all-ones ciphertext, start-while-busy,
// mid-run reset and (when SPECK_KEY_CACHE_EN is defined) key-cache latency.
module tb_speck_decrypt_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [63:0] key_l = '0;
  logic [63:0] key_k = '0;
  logic [63:0] ct_x = '0;
  logic [63:0] ct_y = '0;
  logic        busy;
  logic        done;
  logic [63:0] pt_x;
  logic [63:0] pt_y;

  int pass_cnt = 0;
  int total_cnt = 0;

  localparam logic [63:0] STD_L  = 64'h0f0e0d0c0b0a0908;
  localparam logic [63:0] STD_K  = 64'h0706050403020100;
  localparam logic [63:0] STD_CX = 64'ha65d985179783265;
  localparam logic [63:0] STD_CY = 64'h7860fedf5c570d18;
  localparam logic [63:0] STD_PX = 64'h6c61766975716520;
  localparam logic [63:0] STD_PY = 64'h7469206564616d20;

`ifdef SPECK_KEY_CACHE_EN
  bit           cache_v = 1'b0;
  logic [127:0] cache_k = '0;
`endif

  speck_decrypt_core dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .key_l (key_l),
    .key_k (key_k),
    .ct_x  (ct_x),
    .ct_y  (ct_y),
    .busy  (busy),
    .done  (done),
    .pt_x  (pt_x),
    .pt_y  (pt_y)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rol64(input logic [63:0] v, input int n);
    return (v << n) | (v >> (64 - n));
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Forward cipher, key schedule generated on the fly.
  function automatic logic [127:0] model_enc(input logic [63:0] kl, input logic [63:0] kk,
                                             input logic [63:0] px, input logic [63:0] py);
    logic [63:0] l, k, x, y;
    l = kl; k = kk; x = px; y = py;
    for (int i = 0; i < 32; i++) begin
      x = (ror64(x, 8) + y) ^ k;
      y = rol64(y, 3) ^ x;
      l = (k + ror64(l, 8)) ^ 64'(i);
      k = rol64(k, 3) ^ l;
    end
    return {x, y};
  endfunction

  function automatic logic [127:0] model_dec(input logic [63:0] kl, input logic [63:0] kk,
                                             input logic [63:0] cx, input logic [63:0] cy);
    logic [63:0] rks [32];
    logic [63:0] l, k, x, y;
    l = kl; k = kk; x = cx; y = cy;
    rks[0] = kk;
    for (int i = 0; i < 31; i++) begin
      l = (k + ror64(l, 8)) ^ 64'(i);
      k = rol64(k, 3) ^ l;
      rks[i+1] = k;
    end
    for (int r = 31; r >= 0; r--) begin
      y = ror64(x ^ y, 3);
      x = rol64((x ^ rks[r]) - y, 8);
    end
    return {x, y};
  endfunction

  // Presents one request; returns after the accepting edge with the
  // latency the bench expects for it.
  task automatic do_start(input logic [63:0] kl, input logic [63:0] kk,
                          input logic [63:0] cx, input logic [63:0] cy,
                          output int lat_exp);
    lat_exp = 64;
`ifdef SPECK_KEY_CACHE_EN
    if (cache_v && cache_k == {kl, kk}) begin
      lat_exp = 33;
    end else begin
      cache_v = 1'b0;
      cache_k = {kl, kk};
    end
`endif
    @(negedge clk);
    key_l = kl; key_k = kk; ct_x = cx; ct_y = cy;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts sample points after the accepting edge until done; -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
`ifdef SPECK_KEY_CACHE_EN
    if (lat > 0) cache_v = 1'b1;
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++;
    if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else pass_cnt++;
    total_cnt++;
    if (pt_x !== 64'h0) $display("FAIL reset_pt_x: got %h expected 0", pt_x); else pass_cnt++;
    total_cnt++;
    if (pt_y !== 64'h0) $display("FAIL reset_pt_y: got %h expected 0", pt_y); else pass_cnt++;
    reset = 1'b0;
`ifdef SPECK_KEY_CACHE_EN
    cache_v = 1'b0;
`endif
  endtask

  task automatic test_standard();
    int lat, lat_exp;
    do_start(STD_L, STD_K, STD_CX, STD_CY, lat_exp);
    wait_done(lat);
    total_cnt++;
    if (lat !== lat_exp) $display("FAIL std_latency: got %0d expected %0d", lat, lat_exp); else pass_cnt++;
    total_cnt++;
    if (pt_x !== STD_PX) $display("FAIL std_pt_x: got %h expected %h", pt_x, STD_PX); else pass_cnt++;
    total_cnt++;
    if (pt_y !== STD_PY) $display("FAIL std_pt_y: got %h expected %h", pt_y, STD_PY); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0) $display("FAIL std_done_pulse: got %b expected 0", done); else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({pt_x, pt_y} !== {STD_PX, STD_PY})
      $display("FAIL std_pt_hold: got %h expected %h", {pt_x, pt_y}, {STD_PX, STD_PY});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat, lat_exp;
    logic [127:0] exp_pt;
    do_start(STD_L, STD_K, STD_CX, STD_CY, lat_exp);
    wait_done(lat);
    total_cnt++;
    if (lat !== lat_exp) $display("FAIL b2b_same_key_latency: got %0d expected %0d", lat, lat_exp); else pass_cnt++;
    total_cnt++;
    if ({pt_x, pt_y} !== {STD_PX, STD_PY})
      $display("FAIL b2b_same_key_pt: got %h expected %h", {pt_x, pt_y}, {STD_PX, STD_PY});
    else pass_cnt++;
    exp_pt = model_dec(STD_L, STD_K ^ 64'h1, STD_CX, STD_CY);
    do_start(STD_L, STD_K ^ 64'h1, STD_CX, STD_CY, lat_exp);
    wait_done(lat);
    total_cnt++;
    if (lat !== 64) $display("FAIL b2b_new_key_latency: got %0d expected 64", lat); else pass_cnt++;
    total_cnt++;
    if ({pt_x, pt_y} !== exp_pt)
      $display("FAIL b2b_new_key_pt: got %h expected %h", {pt_x, pt_y}, exp_pt);
    else pass_cnt++;
  endtask

  task automatic test_boundary_wrap();
    int lat, lat_exp;
    logic [127:0] exp_pt;
    logic [127:0] re_ct;
    exp_pt = model_dec(STD_L, STD_K, 64'hffffffffffffffff, 64'hffffffffffffffff);
    do_start(STD_L, STD_K, 64'hffffffffffffffff, 64'hffffffffffffffff, lat_exp);
    wait_done(lat);
    total_cnt++;
    if (lat !== lat_exp) $display("FAIL wrap_latency: got %0d expected %0d", lat, lat_exp); else pass_cnt++;
    total_cnt++;
    if ({pt_x, pt_y} !== exp_pt) $display("FAIL wrap_pt: got %h expected %h", {pt_x, pt_y}, exp_pt); else pass_cnt++;
    re_ct = model_enc(STD_L, STD_K, pt_x, pt_y);
    total_cnt++;
    if (re_ct !== {2{64'hffffffffffffffff}})
      $display("FAIL wrap_reencrypt: got %h expected all ones", re_ct);
    else pass_cnt++;
  endtask

  task automatic test_zero();
    int lat, lat_exp;
    logic [127:0] exp_pt;
    logic [127:0] re_ct;
    exp_pt = model_dec(64'h0, 64'h0, 64'h0, 64'h0);
    do_start(64'h0, 64'h0, 64'h0, 64'h0, lat_exp);
    wait_done(lat);
    total_cnt++;
    if (lat !== lat_exp) $display("FAIL zero_latency: got %0d expected %0d", lat, lat_exp); else pass_cnt++;
    total_cnt++;
    if ({pt_x, pt_y} !== exp_pt) $display("FAIL zero_pt: got %h expected %h", {pt_x, pt_y}, exp_pt); else pass_cnt++;
    re_ct = model_enc(64'h0, 64'h0, pt_x, pt_y);
    total_cnt++;
    if (re_ct !== 128'h0) $display("FAIL zero_reencrypt: got %h expected 0", re_ct); else pass_cnt++;
  endtask

  task automatic test_start_while_busy();
    int lat_exp;
    int done_cnt;
    do_start(STD_L, STD_K, STD_CX, STD_CY, lat_exp);
    done_cnt = 0;
    for (int n = 1; n <= 70; n++) begin
      @(negedge clk);
      start = ((n == 5) || (n == 40)) && (n < lat_exp);
      if (done === 1'b1) done_cnt++;
      if (n <= lat_exp) begin
        total_cnt++;
        if (busy !== (n < lat_exp))
          $display("FAIL busy_profile_n%0d: got %b expected %b", n, busy, (n < lat_exp));
        else pass_cnt++;
        total_cnt++;
        if (done !== (n == lat_exp))
          $display("FAIL done_profile_n%0d: got %b expected %b", n, done, (n == lat_exp));
        else pass_cnt++;
      end
    end
    start = 1'b0;
`ifdef SPECK_KEY_CACHE_EN
    cache_v = 1'b1;
`endif
    total_cnt++;
    if (done_cnt !== 1) $display("FAIL busy_single_done: got %0d expected 1", done_cnt); else pass_cnt++;
    total_cnt++;
    if ({pt_x, pt_y} !== {STD_PX, STD_PY})
      $display("FAIL busy_pt: got %h expected %h", {pt_x, pt_y}, {STD_PX, STD_PY});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    int lat, lat_exp;
    do_start(STD_L ^ 64'h1, STD_K, STD_CX, STD_CY, lat_exp);
    for (int n = 1; n <= 20; n++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL midreset_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++;
    if (done !== 1'b0) $display("FAIL midreset_done: got %b expected 0", done); else pass_cnt++;
    total_cnt++;
    if ({pt_x, pt_y} !== 128'h0) $display("FAIL midreset_pt: got %h expected 0", {pt_x, pt_y}); else pass_cnt++;
    reset = 1'b0;
`ifdef SPECK_KEY_CACHE_EN
    cache_v = 1'b0;
`endif
    do_start(STD_L, STD_K, STD_CX, STD_CY, lat_exp);
    wait_done(lat);
    total_cnt++;
    if (lat !== 64) $display("FAIL midreset_latency: got %0d expected 64", lat); else pass_cnt++;
    total_cnt++;
    if ({pt_x, pt_y} !== {STD_PX, STD_PY})
      $display("FAIL midreset_pt_after: got %h expected %h", {pt_x, pt_y}, {STD_PX, STD_PY});
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_standard();
    test_back_to_back();
    test_boundary_wrap();
    test_zero();
    test_start_while_busy();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
